// File: rtl/mem_port_arbiter.sv
// Arbiter that shares the single instruction/data memory between the CPU datapath and the program-loader/DFT port.
// It grants one requester per cycle and bounds loader starvation by MAX_WAIT. The loader can also hold the grant with a burst lock.
module mem_port_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int MAX_WAIT  = 8,
  parameter int WAIT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [BIT_WIDTH-1:0] cpu_addr,
  input  logic [BIT_WIDTH-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic                 cpu_stall,
  input  logic                 ldr_req,
  input  logic                 ldr_we,
  input  logic                 ldr_lock,
  input  logic [BIT_WIDTH-1:0] ldr_addr,
  input  logic [BIT_WIDTH-1:0] ldr_wdata,
  output logic                 ldr_ack,
  output logic [BIT_WIDTH-1:0] rdata,
  output logic [BIT_WIDTH-1:0] mem_addr,
  output logic [BIT_WIDTH-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [BIT_WIDTH-1:0] mem_rdata,
  output logic [1:0]           dbgGnt,
  output logic [WAIT_W-1:0]    dbgWaitCnt
);

  // Handshake: a requester raises req and holds req/we/addr/wdata stable until the cycle in
  // which its ack is high; that cycle is the memory access. Dropping req before ack cancels it.

  typedef enum logic [1:0] {
    GntIdle = 2'd0,
    GntCpu  = 2'd1,
    GntLdr  = 2'd2
  } gntT;

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  gntT               gnt;
  gntT               gntNext;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitNext;
  logic              starved;

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt     <= GntIdle;
      waitCnt <= '0;
    end else begin
      gnt     <= gntNext;
      waitCnt <= waitNext;
    end
  end

  assign cpu_ack   = ~rst & (gnt == GntCpu) & cpu_req;
  assign ldr_ack   = ~rst & (gnt == GntLdr) & ldr_req;
  assign cpu_stall = cpu_req & ~cpu_ack;

  // The access that ends a starvation wait must not re-trigger the force-grant.
  // waitCnt is still saturated in that ack cycle, so the CPU gets the grant back on the next edge.
  assign starved = ldr_req & ~ldr_ack & (waitCnt == MaxWait);

  always_comb begin
    gntNext = GntIdle;
    if (ldr_lock & ldr_req & (gnt == GntLdr)) begin
      gntNext = GntLdr;
    end else if (starved) begin
      gntNext = GntLdr;
    end else if (cpu_req) begin
      gntNext = GntCpu;
    end else if (ldr_req) begin
      gntNext = GntLdr;
    end
  end

  always_comb begin
    waitNext = waitCnt;
    if (~ldr_req | ldr_ack) begin
      waitNext = '0;
    end else if (waitCnt != MaxWait) begin
      waitNext = waitCnt + 1'b1;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (gnt)
      GntCpu: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we & cpu_ack;
      end
      GntLdr: begin
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        mem_we    = ldr_we & ldr_ack;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
      end
    endcase
  end

  assign rdata      = mem_rdata;
  assign dbgGnt     = gnt;
  assign dbgWaitCnt = waitCnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand sequences for streaming, collision, lock and reset.
// A small behavioural memory sits on the mem_* port.
module tb_mem_port_arbiter;
  localparam int W = 32;
  localparam int MaxWaitP = 8;
  localparam int WaitW = $clog2(MaxWaitP + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cpuReq, cpuWe, cpuAck, cpuStall;
  logic [W-1:0] cpuAddr, cpuWdata;
  logic ldrReq, ldrWe, ldrLock, ldrAck;
  logic [W-1:0] ldrAddr, ldrWdata;
  logic [W-1:0] rdata, memAddr, memWdata, memRdata;
  logic memWe;
  logic [1:0] dbgGnt;
  logic [WaitW-1:0] dbgWaitCnt;

  mem_port_arbiter #(.BIT_WIDTH(W), .MAX_WAIT(MaxWaitP)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_ack(cpuAck), .cpu_stall(cpuStall),
    .ldr_req(ldrReq), .ldr_we(ldrWe), .ldr_lock(ldrLock), .ldr_addr(ldrAddr),
    .ldr_wdata(ldrWdata), .ldr_ack(ldrAck),
    .rdata(rdata), .mem_addr(memAddr), .mem_wdata(memWdata), .mem_we(memWe),
    .mem_rdata(memRdata), .dbgGnt(dbgGnt), .dbgWaitCnt(dbgWaitCnt)
  );

  // Behavioural memory: combinational read, write on the rising edge, 256 words.
  logic [W-1:0] mem [0:255];
  logic memInit;

  function automatic logic [W-1:0] preVal(input int idx);
    return 32'hA500_0000 | (idx * 32'h0101);
  endfunction

  assign memRdata = mem[memAddr[9:2]];
  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 256; i++) mem[i] <= preVal(i);
    end else if (memWe) begin
      mem[memAddr[9:2]] <= memWdata;
    end
  end

  int checks = 0;
  int failures = 0;
  logic [W-1:0] expQ[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idleInputs();
    cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWdata = '0;
    ldrReq = 0; ldrWe = 0; ldrLock = 0; ldrAddr = '0; ldrWdata = '0;
  endtask

  typedef struct {
    logic         r;
    logic         cReq;
    logic         cWe;
    logic [W-1:0] cAddr;
    logic         lReq;
    logic         lWe;
    logic [W-1:0] lAddr;
    logic         eCpuAck;
    logic         eLdrAck;
    logic         eStall;
    logic         eMemWe;
    logic [W-1:0] eMemAddr;
  } vecT;

  function automatic vecT mk(input logic r, input logic cReq, input logic cWe, input logic [W-1:0] cAddr,
                             input logic lReq, input logic lWe, input logic [W-1:0] lAddr,
                             input logic eCpuAck, input logic eLdrAck, input logic eStall,
                             input logic eMemWe, input logic [W-1:0] eMemAddr);
    vecT v;
    v.r = r; v.cReq = cReq; v.cWe = cWe; v.cAddr = cAddr;
    v.lReq = lReq; v.lWe = lWe; v.lAddr = lAddr;
    v.eCpuAck = eCpuAck; v.eLdrAck = eLdrAck; v.eStall = eStall;
    v.eMemWe = eMemWe; v.eMemAddr = eMemAddr;
    return v;
  endfunction

  vecT vecs[10];

  initial begin
    rst = 1; memInit = 1;
    idleInputs();
    repeat (3) nextCycle();
    memInit = 0;
    sample();
    chk("rst_cpu_ack", {31'd0, cpuAck}, 0);
    chk("rst_ldr_ack", {31'd0, ldrAck}, 0);
    chk("rst_mem_we", {31'd0, memWe}, 0);
    chk("rst_mem_addr", memAddr, 0);

    // Reset with a pending CPU write, release, aborted CPU pulse under loader grant.
    vecs[0] = mk(1, 1, 1, 'h40, 0, 0, 'h00, 0, 0, 1, 0, 'h00);
    vecs[1] = mk(1, 1, 1, 'h40, 0, 0, 'h00, 0, 0, 1, 0, 'h00);
    vecs[2] = mk(0, 1, 1, 'h40, 0, 0, 'h00, 0, 0, 1, 0, 'h00);
    vecs[3] = mk(0, 1, 1, 'h40, 0, 0, 'h00, 1, 0, 0, 1, 'h40);
    vecs[4] = mk(0, 0, 1, 'h40, 0, 0, 'h00, 0, 0, 0, 0, 'h40);
    vecs[5] = mk(0, 0, 0, 'h40, 0, 0, 'h00, 0, 0, 0, 0, 'h00);
    vecs[6] = mk(0, 0, 0, 'h40, 1, 0, 'h80, 0, 0, 0, 0, 'h00);
    vecs[7] = mk(0, 1, 1, 'h40, 1, 0, 'h80, 0, 1, 1, 0, 'h80);
    vecs[8] = mk(0, 0, 1, 'h40, 0, 0, 'h80, 0, 0, 0, 0, 'h40);
    vecs[9] = mk(0, 0, 0, 'h40, 0, 0, 'h80, 0, 0, 0, 0, 'h00);

    for (int i = 0; i < 10; i++) begin
      nextCycle();
      rst = vecs[i].r; cpuReq = vecs[i].cReq; cpuWe = vecs[i].cWe; cpuAddr = vecs[i].cAddr;
      cpuWdata = 'h11; ldrReq = vecs[i].lReq; ldrWe = vecs[i].lWe; ldrAddr = vecs[i].lAddr;
      ldrLock = 0; ldrWdata = 'h55;
      sample();
      chk($sformatf("vec%0d_cpu_ack", i), {31'd0, cpuAck}, {31'd0, vecs[i].eCpuAck});
      chk($sformatf("vec%0d_ldr_ack", i), {31'd0, ldrAck}, {31'd0, vecs[i].eLdrAck});
      chk($sformatf("vec%0d_stall", i), {31'd0, cpuStall}, {31'd0, vecs[i].eStall});
      chk($sformatf("vec%0d_mem_we", i), {31'd0, memWe}, {31'd0, vecs[i].eMemWe});
      chk($sformatf("vec%0d_mem_addr", i), memAddr, vecs[i].eMemAddr);
    end
    chk("vec_write_landed", mem[16], 'h11);
    chk("vec_ldr_read_only", mem[32], preVal(32));

    // CPU read stream: ten cycles of held request, reads advance on each ack.
    idleInputs();
    expQ.delete();
    for (int i = 0; i < 9; i++) expQ.push_back(preVal(i));
    begin
      logic [W-1:0] a;
      a = '0;
      for (int k = 1; k <= 10; k++) begin
        nextCycle();
        cpuReq = 1; cpuWe = 0; cpuAddr = a;
        sample();
        chk($sformatf("stream%0d_ack", k), {31'd0, cpuAck}, {31'd0, k >= 2});
        chk($sformatf("stream%0d_stall", k), {31'd0, cpuStall}, {31'd0, k == 1});
        if (cpuAck && expQ.size() > 0) begin
          chk($sformatf("stream%0d_rdata", k), rdata, expQ.pop_front());
          a = a + 4;
        end
      end
    end
    chk("stream_reads_left", expQ.size(), 0);
    nextCycle(); idleInputs(); cpuWe = 1;
    sample();
    chk("stream_tail_no_we", {31'd0, memWe}, 0);
    nextCycle(); idleInputs();

    // Collision from idle: CPU wins until the loader has waited MAX_WAIT cycles.
    for (int k = 1; k <= 12; k++) begin
      nextCycle();
      cpuReq = 1; cpuWe = 0; cpuAddr = 'h10;
      ldrReq = (k <= 10); ldrWe = 1; ldrAddr = 'h100; ldrWdata = 32'hDEADBEEF; ldrLock = 0;
      sample();
      chk($sformatf("coll%0d_cpu_ack", k), {31'd0, cpuAck}, {31'd0, (k >= 2 && k <= 9) || k >= 11});
      chk($sformatf("coll%0d_ldr_ack", k), {31'd0, ldrAck}, {31'd0, k == 10});
      chk($sformatf("coll%0d_mem_we", k), {31'd0, memWe}, {31'd0, k == 10});
    end
    nextCycle(); idleInputs();
    chk("coll_mem", mem[64], 32'hDEADBEEF);
    nextCycle(); idleInputs();

    // Locked loader burst of four writes while the CPU waits.
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      ldrReq = (k <= 5); ldrLock = (k <= 4); ldrWe = 1;
      ldrAddr = (k >= 2) ? W'('h200 + 4 * (k - 2)) : W'('h200);
      ldrWdata = W'('h1000 + k);
      cpuReq = (k >= 2); cpuWe = 0; cpuAddr = 'h20;
      sample();
      chk($sformatf("lock%0d_ldr_ack", k), {31'd0, ldrAck}, {31'd0, k >= 2 && k <= 5});
      chk($sformatf("lock%0d_stall", k), {31'd0, cpuStall}, {31'd0, k >= 2 && k <= 5});
      chk($sformatf("lock%0d_cpu_ack", k), {31'd0, cpuAck}, {31'd0, k == 6});
      if (k >= 2 && k <= 5) chk($sformatf("lock%0d_mem_addr", k), memAddr, ldrAddr);
    end
    nextCycle(); idleInputs();
    for (int j = 0; j < 4; j++) chk($sformatf("lock_mem%0d", j), mem[128 + j], W'('h1002 + j));
    nextCycle(); idleInputs();

    // Reset landing in a loader write cycle must suppress the write.
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      rst = (k == 2);
      ldrReq = 1; ldrWe = 1; ldrAddr = 'h300; ldrWdata = 32'hCAFEF00D; ldrLock = 0;
      sample();
      chk($sformatf("rstw%0d_ldr_ack", k), {31'd0, ldrAck}, {31'd0, k == 4});
      chk($sformatf("rstw%0d_mem_we", k), {31'd0, memWe}, {31'd0, k == 4});
      if (k == 3) chk("rstw_mem_unchanged", mem[192], preVal(192));
    end
    nextCycle(); idleInputs();
    chk("rstw_mem_written", mem[192], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
